// File: rtl/memory_writeback.sv
// memory_writeback
//   Final stage of the TinyRisc-V core. Accepts one result bundle per cycle in
//   IDLE. ALU results go straight to the register-file write port. Loads and
//   stores are issued on the data-memory request/ack bus. Load data is aligned
//   and extended before it is written back.
//
// Handshakes
//   Upstream: a bundle transfers on a clock edge where in_valid && in_ready.
//   in_ready is combinational and high only in IDLE. It therefore drops for the
//   whole memory access, including the write-back cycle of a load.
//   Memory: dmem_req is registered. It stays high, with dmem_we/addr/be/wdata
//   held stable, until the first cycle in which dmem_ack is sampled high. An
//   ack seen outside MEM is ignored.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   in_valid/in_ready upstream handshake
//   opcode, func3     instruction class and access size/sign
//   wb_reg, rd_num    destination register enable / index
//   rd_data           ALU result, and the byte address for loads/stores
//   rs2_data          store data
//   dmem_*            data-memory request/ack bus (word address, byte enables)
//   wr_en/num/data    register-file write port (one-cycle pulse)
//   misalign_exc      pulse: misaligned access or illegal func3 on a memory op
//   bus_err           pulse: no dmem_ack within ACK_TIMEOUT cycles
//
// Parameters
//   ACK_TIMEOUT       MEM cycles without an ack before the access is aborted.
//                     A value of 0 disables the timeout.
//   TIMER_W           timer width. ACK_TIMEOUT must fit in TIMER_W bits.
module memory_writeback #(
  parameter int ACK_TIMEOUT = 255,
  parameter int TIMER_W     = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  opcode,
  input  logic [2:0]  func3,
  input  logic        wb_reg,
  input  logic [4:0]  rd_num,
  input  logic [31:0] rd_data,
  input  logic [31:0] rs2_data,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        wr_en,
  output logic [4:0]  wr_num,
  output logic [31:0] wr_data,
  output logic        misalign_exc,
  output logic        bus_err
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [TIMER_W-1:0] TIMEOUT_V = TIMER_W'(ACK_TIMEOUT);
  localparam bit TIMEOUT_EN = (ACK_TIMEOUT != 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MEM  = 2'd1,
    S_WB   = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Context of the load in flight, captured when the bundle is accepted.
  logic [2:0]         ld_func3_q, ld_func3_d;
  logic [1:0]         ld_off_q, ld_off_d;
  logic               ld_wb_q, ld_wb_d;
  logic [4:0]         ld_rd_q, ld_rd_d;
  logic [TIMER_W-1:0] timer_q, timer_d;

  // Next values of the registered outputs.
  logic        req_d, we_d, wr_en_d, misalign_d, bus_err_d;
  logic [31:0] addr_d, wdata_d, wr_data_d;
  logic [3:0]  be_d;
  logic [4:0]  wr_num_d;

  // Decode of the incoming bundle.
  logic accept, is_load, is_store, is_mem, legal, aligned, mem_ok;
  logic timeout_hit;
  logic [TIMER_W-1:0] timer_inc;

  assign in_ready = (state == S_IDLE);
  assign accept   = in_valid && in_ready;
  assign is_load  = (opcode == OP_LOAD);
  assign is_store = (opcode == OP_STORE);
  assign is_mem   = is_load || is_store;

  always_comb begin
    legal = 1'b0;
    if (is_load) begin
      legal = (func3 == 3'b000) || (func3 == 3'b001) || (func3 == 3'b010) ||
              (func3 == 3'b100) || (func3 == 3'b101);
    end else if (is_store) begin
      legal = (func3 == 3'b000) || (func3 == 3'b001) || (func3 == 3'b010);
    end
  end

  // func3[1:0] is the access size for both loads and stores:
  // 00 byte, 01 halfword, 10 word.
  always_comb begin
    case (func3[1:0])
      2'b01:   aligned = (rd_data[0] == 1'b0);
      2'b10:   aligned = (rd_data[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase
  end

  assign mem_ok = is_mem && legal && aligned;

  // The timer counts MEM cycles that ended without an ack. Timeout fires on
  // the cycle whose count would reach ACK_TIMEOUT. An ack seen in that same
  // cycle has priority over the timeout.
  assign timer_inc   = timer_q + 1'b1;
  assign timeout_hit = TIMEOUT_EN && (timer_inc == TIMEOUT_V);

  function automatic logic [31:0] load_extend(input logic [2:0]  f3,
                                              input logic [1:0]  off,
                                              input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  load_extend = {{24{b[7]}}, b};
      3'b100:  load_extend = {24'd0, b};
      3'b001:  load_extend = {{16{h[15]}}, h};
      3'b101:  load_extend = {16'd0, h};
      default: load_extend = w;
    endcase
  endfunction

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept && mem_ok) state_nxt = S_MEM;
      S_MEM: begin
        if (dmem_ack)         state_nxt = dmem_we ? S_IDLE : S_WB;
        else if (timeout_hit) state_nxt = S_IDLE;
      end
      S_WB:    state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output logic: computes the next value of every registered output.
  always_comb begin
    req_d      = dmem_req;
    we_d       = dmem_we;
    addr_d     = dmem_addr;
    wdata_d    = dmem_wdata;
    be_d       = dmem_be;
    wr_en_d    = 1'b0;
    wr_num_d   = wr_num;
    wr_data_d  = wr_data;
    misalign_d = 1'b0;
    bus_err_d  = 1'b0;
    timer_d    = timer_q;
    ld_func3_d = ld_func3_q;
    ld_off_d   = ld_off_q;
    ld_wb_d    = ld_wb_q;
    ld_rd_d    = ld_rd_q;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (is_mem) begin
            if (mem_ok) begin
              req_d      = 1'b1;
              we_d       = is_store;
              addr_d     = {rd_data[31:2], 2'b00};
              timer_d    = '0;
              ld_func3_d = func3;
              ld_off_d   = rd_data[1:0];
              ld_wb_d    = wb_reg;
              ld_rd_d    = rd_num;
              be_d       = 4'b0000;
              wdata_d    = 32'd0;
              if (is_store) begin
                // Store data is replicated across lanes so the memory
                // only needs to honour the byte enables.
                case (func3[1:0])
                  2'b00: begin
                    be_d    = 4'b0001 << rd_data[1:0];
                    wdata_d = {4{rs2_data[7:0]}};
                  end
                  2'b01: begin
                    be_d    = 4'b0011 << rd_data[1:0];
                    wdata_d = {2{rs2_data[15:0]}};
                  end
                  default: begin
                    be_d    = 4'b1111;
                    wdata_d = rs2_data;
                  end
                endcase
              end
            end else begin
              misalign_d = 1'b1;
            end
          end else if (wb_reg && (rd_num != 5'd0)) begin
            wr_en_d   = 1'b1;
            wr_num_d  = rd_num;
            wr_data_d = rd_data;
          end
        end
      end
      S_MEM: begin
        if (dmem_ack) begin
          req_d = 1'b0;
          if (!dmem_we) begin
            wr_en_d   = ld_wb_q && (ld_rd_q != 5'd0);
            wr_num_d  = ld_rd_q;
            wr_data_d = load_extend(ld_func3_q, ld_off_q, dmem_rdata);
          end
        end else if (timeout_hit) begin
          req_d     = 1'b0;
          bus_err_d = 1'b1;
        end else if (TIMEOUT_EN) begin
          timer_d = timer_inc;
        end
      end
      default: ;
    endcase
  end

  // Registered outputs and load context
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= 32'd0;
      dmem_wdata   <= 32'd0;
      dmem_be      <= 4'd0;
      wr_en        <= 1'b0;
      wr_num       <= 5'd0;
      wr_data      <= 32'd0;
      misalign_exc <= 1'b0;
      bus_err      <= 1'b0;
      timer_q      <= '0;
      ld_func3_q   <= 3'd0;
      ld_off_q     <= 2'd0;
      ld_wb_q      <= 1'b0;
      ld_rd_q      <= 5'd0;
    end else begin
      dmem_req     <= req_d;
      dmem_we      <= we_d;
      dmem_addr    <= addr_d;
      dmem_wdata   <= wdata_d;
      dmem_be      <= be_d;
      wr_en        <= wr_en_d;
      wr_num       <= wr_num_d;
      wr_data      <= wr_data_d;
      misalign_exc <= misalign_d;
      bus_err      <= bus_err_d;
      timer_q      <= timer_d;
      ld_func3_q   <= ld_func3_d;
      ld_off_q     <= ld_off_d;
      ld_wb_q      <= ld_wb_d;
      ld_rd_q      <= ld_rd_d;
    end
  end

endmodule

// File: doc/memory_writeback.md
Name: memory_writeback

Overview:
Final pipeline stage of the TinyRisc-V core. It consumes the decode/execute result bundle (opcode, func3, wb_reg, rd_num, rd_data, store data) and performs load/store accesses on the data-memory request/ack bus. Load data is aligned and sign- or zero-extended; stores get byte enables. Register-file writes are issued as one-cycle pulses. While a memory access is outstanding, the stage stalls upstream through in_ready.

Parameters:
ACK_TIMEOUT, 255, cycles to wait for dmem_ack before aborting with bus_err; 0 disables the timeout
TIMER_W, 8, width of the timeout counter; must hold ACK_TIMEOUT

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
in_valid  in  1  result bundle valid this cycle
in_ready  out  1  stage accepts bundle; combinational, high only in IDLE
opcode  in  7  instruction opcode
func3  in  3  instruction func3
wb_reg  in  1  instruction writes rd
rd_num  in  5  destination register
rd_data  in  32  ALU result; the byte address for load/store
rs2_data  in  32  store data
dmem_req  out  1  memory request, registered
dmem_we  out  1  1 = store, 0 = load
dmem_addr  out  32  word address {addr[31:2],2'b00}
dmem_wdata  out  32  lane-replicated store data
dmem_be  out  4  byte enables (0000 on loads)
dmem_ack  in  1  memory done; rdata valid when loading
dmem_rdata  in  32  load word
wr_en  out  1  register-file write pulse
wr_num  out  5  register-file write index
wr_data  out  32  register-file write data
misalign_exc  out  1  one-cycle pulse: misaligned or illegal func3 memory op
bus_err  out  1  one-cycle pulse: ack timeout

Behaviour:
- Reset: state=IDLE. All registered outputs are 0: dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, wr_en, wr_num, wr_data, misalign_exc, bus_err. Timer is 0.
- Reset mid-access drops dmem_req immediately. A late dmem_ack arriving in IDLE is ignored.
- States: IDLE, MEM, WB.
- IDLE, in_valid=1, opcode=LOAD (0000011) or STORE (0100011):
  - Legal func3: load 000/001/010/100/101; store 000/001/010.
  - Alignment: halfword needs addr[0]=0; word needs addr[1:0]=00.
  - Legal and aligned: next cycle dmem_req=1 with addr, we, be, wdata; go to MEM.
  - Illegal or misaligned: misalign_exc=1 next cycle; no request, no write; stay in IDLE.
- IDLE, in_valid=1, any other opcode: if wb_reg=1 and rd_num!=0, the next cycle has wr_en=1, wr_num=rd_num, wr_data=rd_data. Otherwise nothing happens. Stay in IDLE, so back-to-back accepts give one write per cycle.
- Store lanes:
  - SB: be=0001<<addr[1:0], wdata={4{rs2[7:0]}}.
  - SH: be=0011<<addr[1:0], wdata={2{rs2[15:0]}}.
  - SW: be=1111, wdata=rs2.
- MEM: dmem_req, dmem_we, dmem_addr, dmem_be and dmem_wdata are held stable until the ack. The timer increments each cycle without ack.
  - dmem_ack=1, store: dmem_req=0 next cycle; go to IDLE.
  - dmem_ack=1, load: capture the extended rdata; dmem_req=0; go to WB.
  - Ack sampled in the same cycle the timer reaches ACK_TIMEOUT: ack wins.
  - Timer reaches ACK_TIMEOUT with no ack (ACK_TIMEOUT!=0): dmem_req=0, bus_err pulses 1 cycle, no write, go to IDLE.
- Load extension (lane chosen by addr[1:0]):
  - LB/LH: sign-extend the byte/halfword.
  - LBU/LHU: zero-extend.
  - LW: whole word.
- WB: wr_en=1 only if wb_reg && rd_num!=0, with wr_num/wr_data from the captured load. Go to IDLE. in_ready=0.
- Load latency: accept cycle t, req at t+1, ack at t+k, wr_en at t+k+1, in_ready again at t+k+2.
- wr_en, misalign_exc and bus_err are single-cycle pulses.

Test Plan:
- ALU write, three back-to-back bundles (opcode 0110011): rd=5/0xA, rd=0/0xB, rd=7/0xC → wr_en at cycles t+1 and t+3 only; rd=0 is suppressed; in_ready stays 1.
- LW at 0x100, rdata=0xDEADBEEF, ack after 3 cycles → dmem_addr=0x100, be=0000, then wr_data=0xDEADBEEF; in_ready=0 from accept+1 until the WB cycle ends.
- LB at 0x103, rdata=0x80FF_FF7F → wr_data=0xFFFFFF80. LBU at the same address → 0x00000080. LHU at 0x102 → 0x000080FF.
- SH at 0x206, rs2=0x1234ABCD → dmem_addr=0x204, be=1100, wdata=0xABCDABCD, we=1; no wr_en.
- LW at 0x102 → misalign_exc pulses once, dmem_req stays 0, no wr_en. Load with func3=011 → misalign_exc.
- ACK_TIMEOUT=4, no ack → bus_err after 4 MEM cycles, req drops. Separately, assert rst during MEM, then release and pulse ack → req=0 immediately and the ack is ignored.
